// File: rtl/rom_reader_defs.sv
// Shared definitions for the PROM reader family: FSM states, mode codes and
// the width helpers used to mask address/data buses to the active chip size.
package rom_reader_defs;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_EMIT   = 3'd3,
      ST_HOLD   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   // Low `width` bits set; callers cast down to their own bus width.
   function automatic logic [15:0] mask(input logic [3:0] width);
      return (16'd1 << width) - 16'd1;
   endfunction

   function automatic logic [3:0] clamp_width(input logic [3:0] width,
                                              input logic [3:0] max_width);
      return ((width == 4'd0) || (width > max_width)) ? max_width : width;
   endfunction

endpackage

// File: rtl/rom_settle_timer.sv
// Loadable down-counter giving the PROM outputs SETTLE_CYCLES clocks to settle
// after an address/select change; also used to time burn pulses.
module rom_settle_timer #(
   parameter int SETTLE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expired
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic [CW-1:0] r_count;

   // Loading SETTLE_CYCLES-1 makes `expired` true on the last of SETTLE_CYCLES clocks.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= CW'(SETTLE_CYCLES - 1);
      end else if (r_count != '0) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign expired = (r_count == '0);

endmodule

// File: rtl/rom_dump_controller.sv
// Run-time configurable PROM reader: manual stepping or full auto sweep that
// streams {address, data} pairs over a valid/ready handshake.
module rom_dump_controller
   import rom_reader_defs::*;
#(
   parameter int MAX_ADDRESS_WIDTH = 9,
   parameter int MAX_DATA_WIDTH    = 8,
   parameter int SELECT_WIDTH      = 4,
   parameter int SETTLE_CYCLES     = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mode,
   input  logic [3:0]                   address_width,
   input  logic [3:0]                   data_width,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         step_up,
   input  logic                         step_down,
   input  logic [MAX_DATA_WIDTH-1:0]    chip_data_in,
   output logic [MAX_ADDRESS_WIDTH-1:0] chip_address,
   output logic [SELECT_WIDTH-1:0]      chip_select_n,
   output logic [MAX_DATA_WIDTH-1:0]    current_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [MAX_ADDRESS_WIDTH-1:0] out_address,
   output logic [MAX_DATA_WIDTH-1:0]    out_data,
   output logic                         busy,
   output logic                         done
);

   state_t                         r_state;
   logic                           r_mode;
   logic [3:0]                     r_addr_width;
   logic [3:0]                     r_data_width;
   logic [MAX_ADDRESS_WIDTH-1:0]   r_address;
   logic [SELECT_WIDTH-1:0]        r_select_n;
   logic [MAX_DATA_WIDTH-1:0]      r_current_data;
   logic                           r_out_valid;
   logic [MAX_ADDRESS_WIDTH-1:0]   r_out_address;
   logic [MAX_DATA_WIDTH-1:0]      r_out_data;
   logic                           r_busy;
   logic                           r_done;

   logic [MAX_ADDRESS_WIDTH-1:0]   w_addr_mask;
   logic [MAX_DATA_WIDTH-1:0]      w_data_mask;
   logic [MAX_DATA_WIDTH-1:0]      w_sample_data;
   logic [MAX_ADDRESS_WIDTH-1:0]   w_addr_up;
   logic [MAX_ADDRESS_WIDTH-1:0]   w_addr_down;
   logic                           w_at_max;
   logic                           w_step_valid;
   logic                           w_timer_load;
   logic                           w_settle_expired;

   // The address mask doubles as max_addr, so wrapping never sets bits above the active width.
   assign w_addr_mask   = MAX_ADDRESS_WIDTH'(mask(r_addr_width));
   assign w_data_mask   = MAX_DATA_WIDTH'(mask(r_data_width));
   assign w_sample_data = chip_data_in & w_data_mask;
   assign w_at_max      = (r_address == w_addr_mask);
   assign w_addr_up     = w_at_max ? '0 : r_address + MAX_ADDRESS_WIDTH'(1);
   assign w_addr_down   = (r_address == '0) ? w_addr_mask : r_address - MAX_ADDRESS_WIDTH'(1);
   assign w_step_valid  = step_up ^ step_down;

   // Timer is reloaded on exactly the edges that enter SETTLE.
   assign w_timer_load = !reset && !abort &&
                         (((r_state == ST_IDLE) && start) ||
                          ((r_state == ST_EMIT) && out_ready && !w_at_max) ||
                          ((r_state == ST_HOLD) && w_step_valid));

   rom_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (w_timer_load),
      .expired (w_settle_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_mode         <= MODE_MANUAL;
         r_addr_width   <= 4'(MAX_ADDRESS_WIDTH);
         r_data_width   <= 4'(MAX_DATA_WIDTH);
         r_address      <= '0;
         r_select_n     <= '1;
         r_current_data <= '0;
         r_out_valid    <= 1'b0;
         r_out_address  <= '0;
         r_out_data     <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // NOTE: abort is checked first so it overrides an EMIT handshake in the same cycle.
         if (abort) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_select_n  <= '1;
            r_busy      <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_mode       <= mode;
                     r_addr_width <= clamp_width(address_width, 4'(MAX_ADDRESS_WIDTH));
                     r_data_width <= clamp_width(data_width, 4'(MAX_DATA_WIDTH));
                     r_address    <= '0;
                     r_select_n   <= '0;
                     r_busy       <= 1'b1;
                     r_state      <= ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (w_settle_expired) r_state <= ST_SAMPLE;
               end
               ST_SAMPLE: begin
                  r_current_data <= w_sample_data;
                  if (r_mode == MODE_AUTO) begin
                     r_out_address <= r_address;
                     r_out_data    <= w_sample_data;
                     r_out_valid   <= 1'b1;
                     r_state       <= ST_EMIT;
                  end else begin
                     r_state <= ST_HOLD;
                  end
               end
               ST_EMIT: begin
                  if (out_ready) begin
                     r_out_valid <= 1'b0;
                     if (w_at_max) begin
                        r_state <= ST_DONE;
                     end else begin
                        r_address <= w_addr_up;
                        r_state   <= ST_SETTLE;
                     end
                  end
               end
               ST_HOLD: begin
                  if (w_step_valid) begin
                     r_address <= step_up ? w_addr_up : w_addr_down;
                     r_state   <= ST_SETTLE;
                  end
               end
               ST_DONE: begin
                  r_done     <= 1'b1;
                  r_select_n <= '1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
               default: begin
                  r_select_n <= '1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign chip_address  = r_address;
   assign chip_select_n = r_select_n;
   assign current_data  = r_current_data;
   assign out_valid     = r_out_valid;
   assign out_address   = r_out_address;
   assign out_data      = r_out_data;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_rom_dump_controller.sv
// Directed-plus-random bench for rom_dump_controller: a ROM array models the
// chip and each sweep is predicted as a queue of {address, data} beats.
module tb_rom_dump_controller;

   localparam int AW     = 9;
   localparam int DW     = 8;
   localparam int SW     = 4;
   localparam int SETTLE = 16;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          mode;
   logic [3:0]    address_width;
   logic [3:0]    data_width;
   logic          start;
   logic          abort;
   logic          step_up;
   logic          step_down;
   logic [DW-1:0] chip_data_in;
   logic [AW-1:0] chip_address;
   logic [SW-1:0] chip_select_n;
   logic [DW-1:0] current_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_address;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;

   logic [DW-1:0] rom [1 << AW];
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;

   rom_dump_controller #(
      .MAX_ADDRESS_WIDTH (AW),
      .MAX_DATA_WIDTH    (DW),
      .SELECT_WIDTH      (SW),
      .SETTLE_CYCLES     (SETTLE)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mode          (mode),
      .address_width (address_width),
      .data_width    (data_width),
      .start         (start),
      .abort         (abort),
      .step_up       (step_up),
      .step_down     (step_down),
      .chip_data_in  (chip_data_in),
      .chip_address  (chip_address),
      .chip_select_n (chip_select_n),
      .current_data  (current_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_address   (out_address),
      .out_data      (out_data),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign chip_data_in = rom[chip_address];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_rom_xor();
      for (int i = 0; i < (1 << AW); i++) rom[i] = DW'(i ^ 'hA5);
   endtask

   task automatic fill_rom_random();
      for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_chip_address"}, 32'(chip_address), 0);
      check({tag, "_chip_select_n"}, 32'(chip_select_n), 32'hF);
      check({tag, "_current_data"}, 32'(current_data), 0);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_address"}, 32'(out_address), 0);
      check({tag, "_out_data"}, 32'(out_data), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
   endtask

   // Auto sweep: the expected stream is every address of the (clamped) chip
   // in order, data masked to the (clamped) data width.
   task automatic run_sweep(input string tag, input logic [3:0] aw, input logic [3:0] dw,
                            input bit rand_ready, input int exp_aw, input int exp_dw);
      beat_t         exp_q[$];
      beat_t         b;
      int            n, beats, stalls, done_cnt, done_edge, first_valid_edge, start_edge, budget;
      logic          stalled;
      logic [AW-1:0] st_a;
      logic [DW-1:0] st_d;
      logic [DW-1:0] dmask;

      n     = 1 << exp_aw;
      dmask = DW'((1 << exp_dw) - 1);
      for (int i = 0; i < n; i++) begin
         b.a = AW'(i);
         b.d = rom[i] & dmask;
         exp_q.push_back(b);
      end

      @(negedge clk);
      mode = 1'b1; address_width = aw; data_width = dw; start = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      start_edge = cyc;
      check({tag, "_start_busy"}, 32'(busy), 1);
      check({tag, "_start_select"}, 32'(chip_select_n), 0);
      check({tag, "_start_address"}, 32'(chip_address), 0);

      beats = 0; stalls = 0; done_cnt = 0; done_edge = -1; first_valid_edge = -1; stalled = 1'b0;
      st_a = '0; st_d = '0;
      budget = n * (SETTLE + 2) * 6 + 50;
      for (int c = 0; c < budget && done_edge < 0; c++) begin
         if (out_valid && first_valid_edge < 0) first_valid_edge = cyc + 1;
         if (stalled) begin
            check({tag, "_stall_valid"}, 32'(out_valid), 1);
            check({tag, "_stall_address"}, 32'(out_address), 32'(st_a));
            check({tag, "_stall_data"}, 32'(out_data), 32'(st_d));
         end
         if (done) begin
            done_cnt++;
            done_edge = cyc + 1;
         end
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, "_extra_beat"}, 32'(out_address), 32'hFFFF_FFFF);
            end else begin
               b = exp_q.pop_front();
               check({tag, "_beat_address"}, 32'(out_address), 32'(b.a));
               check({tag, "_beat_data"}, 32'(out_data), 32'(b.d));
            end
            beats++;
            stalled = 1'b0;
         end else if (out_valid) begin
            stalls++;
            stalled = 1'b1;
            st_a = out_address;
            st_d = out_data;
         end else begin
            stalled = 1'b0;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;

      check({tag, "_done_seen"}, 32'(done_edge >= 0), 1);
      check({tag, "_beats"}, 32'(beats), 32'(n));
      check({tag, "_first_valid_latency"}, 32'(first_valid_edge - start_edge), SETTLE + 2);
      check({tag, "_done_latency"}, 32'(done_edge - start_edge), 32'(n * (SETTLE + 2) + 2 + stalls));
      for (int c = 0; c < 4; c++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check({tag, "_done_count"}, 32'(done_cnt), 1);
      check({tag, "_end_busy"}, 32'(busy), 0);
      check({tag, "_end_select"}, 32'(chip_select_n), 32'hF);
      check({tag, "_end_address"}, 32'(chip_address), 32'(n - 1));
   endtask

   // Manual step: address moves on the step edge, data lands SETTLE+1 edges later.
   task automatic manual_step(input string tag, input logic up, input logic down,
                              input int exp_addr, input bit inject_step);
      int            j;
      logic [DW-1:0] prev;
      prev = current_data;
      step_up = up; step_down = down;
      @(negedge clk);
      step_up = 1'b0; step_down = 1'b0;
      j = cyc;
      check({tag, "_address"}, 32'(chip_address), 32'(exp_addr));
      for (int c = 1; c <= SETTLE + 1; c++) begin
         step_up = inject_step && (c == 3);
         @(negedge clk);
         if (c == SETTLE && rom[exp_addr] != prev)
            check({tag, "_data_early"}, 32'(current_data), 32'(prev));
      end
      step_up = 1'b0;
      check({tag, "_latency"}, 32'(cyc - j), SETTLE + 1);
      check({tag, "_data"}, 32'(current_data), 32'(rom[exp_addr]));
      check({tag, "_address_after"}, 32'(chip_address), 32'(exp_addr));
      check({tag, "_no_valid"}, 32'(out_valid), 0);
   endtask

   initial begin
      int  t0, beats, dcnt;
      bit  hit;

      reset = 1'b1; mode = 1'b0; address_width = 4'd9; data_width = 4'd8;
      start = 1'b0; abort = 1'b0; step_up = 1'b0; step_down = 1'b0; out_ready = 1'b0;
      fill_rom_xor();
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;
      @(negedge clk);

      // Auto sweep of a 256x4 chip with ready held high.
      run_sweep("sweep_256x4", 4'd8, 4'd4, 1'b0, 8, 4);

      // Full 512x8 sweep with random backpressure; width 12 clamps to 9.
      fill_rom_random();
      run_sweep("backpressure_w12", 4'd12, 4'd8, 1'b1, 9, 8);

      // Manual stepping with wrap in both directions.
      @(negedge clk);
      mode = 1'b0; address_width = 4'd9; data_width = 4'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      repeat (SETTLE + 1) @(negedge clk);
      check("manual_first_latency", 32'(cyc - t0), SETTLE + 1);
      check("manual_first_data", 32'(current_data), 32'(rom[0]));
      check("manual_busy", 32'(busy), 1);
      manual_step("man_down_wrap", 1'b0, 1'b1, 511, 1'b0);
      manual_step("man_up_wrap", 1'b1, 1'b0, 0, 1'b0);
      manual_step("man_up", 1'b1, 1'b0, 1, 1'b1);
      manual_step("man_both", 1'b1, 1'b1, 1, 1'b0);
      manual_step("man_up_again", 1'b1, 1'b0, 2, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("manual_abort_busy", 32'(busy), 0);
      check("manual_abort_select", 32'(chip_select_n), 32'hF);
      check("manual_abort_address", 32'(chip_address), 2);

      // Abort in EMIT with ready high in the same cycle.
      fill_rom_xor();
      @(negedge clk);
      mode = 1'b1; address_width = 4'd4; data_width = 4'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      beats = 0; hit = 1'b0;
      for (int c = 0; c < 500; c++) begin
         out_ready = 1'b1;
         if (out_valid && out_address == 3) begin
            abort = 1'b1;
            hit = 1'b1;
            break;
         end
         if (out_valid) beats++;
         @(negedge clk);
      end
      @(negedge clk);
      abort = 1'b0; out_ready = 1'b0;
      check("abort_reached_emit", 32'(hit), 1);
      check("abort_prior_beats", 32'(beats), 3);
      check("abort_valid", 32'(out_valid), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_select", 32'(chip_select_n), 32'hF);
      check("abort_address", 32'(chip_address), 3);
      dcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("abort_no_done", 32'(dcnt), 0);
      check("abort_address_held", 32'(chip_address), 3);

      // Reset in the middle of a sweep.
      @(negedge clk);
      mode = 1'b1; address_width = 4'd9; data_width = 4'd8; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 * (SETTLE + 2) + 100; c++) begin
         if (chip_address == 100) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("reset_reached_100", 32'(hit), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; out_ready = 1'b0;
      check_reset_outputs("mid_reset");
      dcnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("mid_reset_no_done", 32'(dcnt), 0);

      // Fresh sweep after reset; width 0 clamps to 9.
      fill_rom_random();
      run_sweep("after_reset_w0", 4'd0, 4'd8, 1'b0, 9, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
